crtc_timing_gen: RTL and testbench

Parametrised, fully programmable raster timing generator for the character-mode CRT subsystem, the successor to the fixed-geometry K580VG75 timing path. It owns the horizontal character counter, the scanline-within-row counter, the row counter and the blink frame counter. From these it produces sync, display-enable, cursor, blink, row-fetch strobes and the end-of-screen interrupt. All geometry is set through a small register file written by the CPU. It drives the row-buffer DMA and pixel serialiser.

---
 rtl/crtc_timing_gen.sv | 163 ++++++++++++++++
 tb/tb_crtc_timing_gen.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/crtc_timing_gen.sv
// Programmable raster timing generator for the character-mode CRT: h/line/row/frame
// counters, sync and enable decodes, cursor, row-fetch strobes and end-of-screen irq.
module crtc_timing_gen #(
  parameter int COL_W   = 7,
  parameter int ROW_W   = 6,
  parameter int LINE_W  = 4,
  parameter int BLINK_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce,
  input  logic              we,
  input  logic              rd,
  input  logic [3:0]        addr,
  input  logic [7:0]        wdata,
  output logic [7:0]        rdata,
  output logic [COL_W-1:0]  col,
  output logic [ROW_W-1:0]  row,
  output logic [LINE_W-1:0] line,
  output logic              de,
  output logic              hrtc,
  output logic              vrtc,
  output logic              cursor,
  output logic              blink,
  output logic              row_start,
  output logic              frame_start,
  output logic              irq
);

  typedef enum logic {ST_ACTIVE = 1'b0, ST_BLANK = 1'b1} vstate_t;

  logic [7:0]         h_total, h_active, hs_start, hs_end, v_blank, vs_len;
  logic [ROW_W-1:0]   v_rows, cur_y;
  logic [LINE_W-1:0]  char_h, ul_line;
  logic [COL_W-1:0]   cur_x;
  logic [3:0]         ctrl;

  vstate_t            vstate;
  logic [7:0]         h, b;
  logic [BLINK_W-1:0] frame;

  logic               enable, inte, blink_en, ul_cursor;
  logic [ROW_W-1:0]   rows_eff;
  logic [7:0]         blank_eff;
  logic               eol, last_line, last_row, last_blank, irq_set;

  // NOTE: the register file is a handful of flops, so it resets to defaults like any other state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_total  <= 8'd88;
      h_active <= 8'd78;
      hs_start <= 8'd80;
      hs_end   <= 8'd88;
      v_rows   <= ROW_W'(30);
      char_h   <= LINE_W'(9);
      v_blank  <= 8'd12;
      vs_len   <= 8'd2;
      ul_line  <= LINE_W'(9);
      cur_x    <= '0;
      cur_y    <= '0;
      ctrl     <= 4'd0;
    end else if (we) begin
      case (addr)
        4'd0:    h_total  <= wdata;
        4'd1:    h_active <= wdata;
        4'd2:    hs_start <= wdata;
        4'd3:    hs_end   <= wdata;
        4'd4:    v_rows   <= ROW_W'(wdata);
        4'd5:    char_h   <= LINE_W'(wdata);
        4'd6:    v_blank  <= wdata;
        4'd7:    vs_len   <= wdata;
        4'd8:    ul_line  <= LINE_W'(wdata);
        4'd9:    cur_x    <= COL_W'(wdata);
        4'd10:   cur_y    <= ROW_W'(wdata);
        4'd11:   ctrl     <= wdata[3:0];
        default: ;
      endcase
    end
  end

  assign enable    = ctrl[0];
  assign inte      = ctrl[1];
  assign blink_en  = ctrl[2];
  assign ul_cursor = ctrl[3];

  // A zero row or blank count behaves as one so the frame never stalls.
  assign rows_eff   = (v_rows == '0) ? ROW_W'(1) : v_rows;
  assign blank_eff  = (v_blank == 8'd0) ? 8'd1 : v_blank;
  assign eol        = h >= h_total;
  assign last_line  = line >= char_h;
  assign last_row   = row >= rows_eff - ROW_W'(1);
  assign last_blank = b >= blank_eff - 8'd1;
  assign irq_set    = ce & eol & (vstate == ST_ACTIVE) & last_line & last_row & inte & enable;

  // NOTE: all state below uses non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vstate      <= ST_ACTIVE;
      h           <= 8'd0;
      b           <= 8'd0;
      line        <= '0;
      row         <= '0;
      frame       <= '0;
      row_start   <= 1'b0;
      frame_start <= 1'b0;
      irq         <= 1'b0;
      rdata       <= 8'd0;
    end else begin
      row_start   <= 1'b0;
      frame_start <= 1'b0;
      if (rd)
        rdata <= {irq, inte, enable, vstate == ST_BLANK, 4'b0000};
      // A set on the same edge as a read wins over the read's clear.
      irq <= irq_set | (irq & ~rd);
      if (ce) begin
        if (!eol) begin
          h <= h + 8'd1;
        end else begin
          h <= 8'd0;
          case (vstate)
            ST_ACTIVE: begin
              if (!last_line) begin
                line <= line + LINE_W'(1);
              end else begin
                line <= '0;
                row  <= row + ROW_W'(1);
                if (last_row) begin
                  vstate <= ST_BLANK;
                  b      <= 8'd0;
                end else begin
                  row_start <= 1'b1;
                end
              end
            end
            ST_BLANK: begin
              if (!last_blank) begin
                b <= b + 8'd1;
              end else begin
                vstate      <= ST_ACTIVE;
                b           <= 8'd0;
                row         <= '0;
                line        <= '0;
                frame       <= frame + BLINK_W'(1);
                row_start   <= 1'b1;
                frame_start <= 1'b1;
              end
            end
            default: vstate <= ST_ACTIVE;
          endcase
        end
      end
    end
  end

  assign col    = COL_W'(h);
  assign de     = (vstate == ST_ACTIVE) & (h < h_active) & enable;
  assign hrtc   = (h >= hs_start) & (h <= hs_end);
  assign vrtc   = (vstate == ST_BLANK) & (b < vs_len);
  assign blink  = frame[BLINK_W-1];
  assign cursor = de & (col == cur_x) & (row == cur_y) &
                  (~blink_en | blink) & (~ul_cursor | (line == ul_line));

endmodule

// File: tb/tb_crtc_timing_gen.sv
// Self-checking bench for crtc_timing_gen: directed steps plus randomized geometry,
// checked against an arithmetic raster model (position = ce count mod frame period).
module tb_crtc_timing_gen;
  localparam int BW = 5;

  logic       clk = 1'b0;
  logic       reset, ce, we, rd;
  logic [3:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic [6:0] col;
  logic [5:0] row;
  logic [3:0] line;
  logic       de, hrtc, vrtc, cursor, blink, row_start, frame_start, irq;

  crtc_timing_gen dut (
    .clk(clk), .reset(reset), .ce(ce), .we(we), .rd(rd), .addr(addr), .wdata(wdata),
    .rdata(rdata), .col(col), .row(row), .line(line), .de(de), .hrtc(hrtc), .vrtc(vrtc),
    .cursor(cursor), .blink(blink), .row_start(row_start), .frame_start(frame_start),
    .irq(irq)
  );

  always #5 clk = ~clk;

  int n_pass, n_checks;

  // Model configuration and state
  int       m_htot, m_hact, m_hss, m_hse, m_vrows, m_charh, m_vblank, m_vslen, m_ul, m_cx, m_cy;
  bit [3:0] m_ctrl;
  int       lp, al, fp, k;
  bit       irq_m;
  logic [7:0] rdata_m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h (k=%0d)", tag, obs, exp, k);
  endtask

  task automatic recompute();
    int vr, vb;
    vr = (m_vrows == 0) ? 1 : m_vrows;
    vb = (m_vblank == 0) ? 1 : m_vblank;
    lp = m_htot + 1;
    al = (m_charh + 1) * vr;
    fp = (al + vb) * lp;
  endtask

  task automatic compare_all(input bit rs_m, input bit fs_m);
    int pos, hl, h, r, ln, bl_line;
    bit act, de_m, cur_m, blink_m;
    pos     = k % fp;
    hl      = pos / lp;
    h       = pos % lp;
    act     = hl < al;
    r       = hl / (m_charh + 1);
    ln      = hl % (m_charh + 1);
    bl_line = hl - al;
    blink_m = ((k / fp) % (1 << BW)) >= (1 << (BW - 1));
    de_m    = act && (h < m_hact) && m_ctrl[0];
    cur_m   = de_m && ((h % 128) == m_cx) && (r == m_cy) &&
              (!m_ctrl[2] || blink_m) && (!m_ctrl[3] || ln == m_ul);
    check("de", de, de_m);
    check("hrtc", hrtc, (h >= m_hss) && (h <= m_hse));
    check("vrtc", vrtc, !act && (bl_line < m_vslen));
    check("cursor", cursor, cur_m);
    check("blink", blink, blink_m);
    check("frame_start", frame_start, fs_m);
    check("irq", irq, irq_m);
    check("rdata", rdata, rdata_m);
    if (act) begin
      check("row", row, r);
      check("line", line, ln);
    end
    if (de_m) check("col", col, h % 128);
    if (k >= fp) check("row_start", row_start, rs_m);
  endtask

  task automatic tick(input bit ce_v, input bit rd_v);
    int pos0, pos;
    bit act0, set_m, rs_m, fs_m;
    logic [7:0] st_old;
    pos0 = k % fp;
    act0 = (pos0 / lp) < al;
    ce = ce_v;
    rd = rd_v;
    @(posedge clk);
    #1;
    ce = 1'b0;
    rd = 1'b0;
    st_old = {irq_m, m_ctrl[1], m_ctrl[0], !act0, 4'b0000};
    if (ce_v) k++;
    pos   = k % fp;
    set_m = ce_v && m_ctrl[0] && m_ctrl[1] && (pos == al * lp);
    if (rd_v) rdata_m = st_old;
    if (set_m) irq_m = 1'b1;
    else if (rd_v) irq_m = 1'b0;
    rs_m = ce_v && (k > 0) && (pos < al * lp) && (pos % (lp * (m_charh + 1)) == 0);
    fs_m = ce_v && (k > 0) && (pos == 0);
    compare_all(rs_m, fs_m);
  endtask

  task automatic step_raw(input bit ce_v);
    ce = ce_v;
    @(posedge clk);
    #1;
    ce = 1'b0;
  endtask

  task automatic wr(input int a, input int d);
    addr  = a[3:0];
    wdata = d[7:0];
    we    = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic do_reset();
    ce = 1'b0; rd = 1'b0; we = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_htot = 88; m_hact = 78; m_hss = 80; m_hse = 88; m_vrows = 30; m_charh = 9;
    m_vblank = 12; m_vslen = 2; m_ul = 9; m_cx = 0; m_cy = 0; m_ctrl = 4'd0;
    k = 0; irq_m = 1'b0; rdata_m = 8'd0;
    recompute();
  endtask

  task automatic prog(input int ht, input int ha, input int hs, input int he, input int vr,
                      input int ch, input int vb, input int vl, input int ul, input int cx,
                      input int cy, input int ct);
    wr(0, ht); wr(1, ha); wr(2, hs); wr(3, he); wr(4, vr); wr(5, ch);
    wr(6, vb); wr(7, vl); wr(8, ul); wr(9, cx); wr(10, cy); wr(11, ct);
    m_htot = ht; m_hact = ha; m_hss = hs; m_hse = he; m_vrows = vr; m_charh = ch;
    m_vblank = vb; m_vslen = vl; m_ul = ul; m_cx = cx; m_cy = cy; m_ctrl = ct[3:0];
    recompute();
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_rdata"}, rdata, 0);
    check({pfx, "_irq"}, irq, 0);
    check({pfx, "_de"}, de, 0);
    check({pfx, "_cursor"}, cursor, 0);
    check({pfx, "_row_start"}, row_start, 0);
    check({pfx, "_frame_start"}, frame_start, 0);
    check({pfx, "_hrtc"}, hrtc, 0);
    check({pfx, "_vrtc"}, vrtc, 0);
    check({pfx, "_blink"}, blink, 0);
    check({pfx, "_row"}, row, 0);
    check({pfx, "_line"}, line, 0);
    check({pfx, "_col"}, col, 0);
  endtask

  initial begin
    bit rdv;
    int first_fs, first_irq, ncur, n, ct;
    int ht, ha, hs, he, vr, ch, vb, vl, ul, cx, cy;
    n_pass = 0; n_checks = 0;
    reset = 1'b1; ce = 1'b0; rd = 1'b0; we = 1'b0; addr = 4'd0; wdata = 8'd0;

    // Reset state
    do_reset();
    check_all_zero("rst");

    // Shrinking H_TOTAL below h ends the line on the next ce
    wr(11, 1);
    repeat (50) step_raw(1'b1);
    check("ht_col_before", col, 50);
    check("ht_de_before", de, 1);
    wr(0, 20);
    check("ht_col_after_wr", col, 50);
    step_raw(1'b1);
    check("ht_eol_col", col, 0);
    check("ht_eol_line", line, 1);
    repeat (20) step_raw(1'b1);
    check("ht_short_col", col, 20);
    check("ht_short_line", line, 1);
    step_raw(1'b1);
    check("ht_next_col", col, 0);
    check("ht_next_line", line, 2);

    // Default geometry, enable+inte, rd colliding with the irq set
    do_reset();
    wr(11, 3);
    m_ctrl = 4'd3;
    first_fs = -1; first_irq = -1;
    for (int i = 0; i < 312 * 89 + 150; i++) begin
      rdv = (k == 300 * 89 - 1) || (k == 300 * 89);
      tick(1'b1, rdv);
      if (frame_start && first_fs < 0) first_fs = k;
      if (irq && first_irq < 0) first_irq = k;
      if (k == 300 * 89) begin
        check("rd_same_edge_rdata7", rdata[7], 0);
        check("rd_same_edge_irq", irq, 1);
      end
      if (k == 300 * 89 + 1) begin
        check("rd_second_rdata7", rdata[7], 1);
        check("rd_second_irq", irq, 0);
      end
    end
    check("frame_period", first_fs, 312 * 89);
    check("irq_rise", first_irq, 300 * 89);

    // Asynchronous reset in the middle of row 12
    do_reset();
    prog(7, 6, 2, 4, 16, 1, 3, 2, 0, 2, 5, 3);
    tick(1'b1, 1'b1);
    for (int i = 0; i < 5000 && k < 203; i++) tick($urandom_range(0, 3) != 0, 1'b0);
    check("mid_reached", k, 203);
    check("mid_row12", row, 12);
    #2 reset = 1'b1;
    #1;
    check_all_zero("mid_rst");
    do_reset();

    // Underline cursor with blink: present only in blink=1 frames
    prog(9, 8, 8, 9, 4, 9, 2, 1, 9, 5, 3, 15);
    ncur = 0;
    for (int i = 0; i < 32 * fp; i++) begin
      tick(1'b1, 1'b0);
      if (cursor) ncur++;
    end
    check("cursor_cycles_32_frames", ncur, 16);

    // Randomized geometry, ce and rd (segment 0 has enable=0, segment 1 enable+inte)
    for (int s = 0; s < 6; s++) begin
      ht = $urandom_range(6, 20);
      ha = $urandom_range(1, ht + 2);
      hs = $urandom_range(0, ht);
      he = $urandom_range(hs, ht + 1);
      vr = $urandom_range(0, 5);
      ch = $urandom_range(0, 3);
      vb = $urandom_range(0, 4);
      vl = $urandom_range(0, 5);
      ul = $urandom_range(0, ch);
      cx = $urandom_range(0, ha);
      cy = $urandom_range(0, vr);
      ct = (s == 0) ? 2 : (s == 1) ? 3 : $urandom_range(0, 15);
      do_reset();
      prog(ht, ha, hs, he, vr, ch, vb, vl, ul, cx, cy, ct);
      wr(12 + (s % 4), $urandom_range(0, 255));
      n = 2 * fp + $urandom_range(0, fp);
      for (int i = 0; i < n; i++)
        tick($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
